// File: rtl/irq_dispatcher_if.sv
// Signal bundle between irq_dispatcher, the interrupt controller and the CPU.
// The master side is the dispatcher; the slave side is the controller/CPU pair.
interface irq_dispatcher_if;
    logic [14:0] irq_lines;
    logic        irq_ack;
    logic        irq_eoi;
    logic        irq_req;
    logic [3:0]  irq_vector;
    logic [14:0] in_service;
    logic        ctl_wr;
    logic        ctl_addr;
    logic [15:0] ctl_din;

    modport master (
        input  irq_lines,
        input  irq_ack,
        input  irq_eoi,
        output irq_req,
        output irq_vector,
        output in_service,
        output ctl_wr,
        output ctl_addr,
        output ctl_din
    );

    modport slave (
        output irq_lines,
        output irq_ack,
        output irq_eoi,
        input  irq_req,
        input  irq_vector,
        input  in_service,
        input  ctl_wr,
        input  ctl_addr,
        input  ctl_din
    );
endinterface

// File: rtl/irq_dispatcher.sv
// Priority interrupt dispatcher: picks the highest eligible line, hands it to the CPU
// with req/ack, clears it in the controller on ack and tracks nested in-service levels.
module irq_dispatcher (
    input  logic                 clk,
    input  logic                 reset_n,
    irq_dispatcher_if.master     bus
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_REQ   = 2'd1,
        ST_CLEAR = 2'd2
    } state_t;

    state_t      state_r, state_s;
    logic        req_r, req_s;
    logic [3:0]  vec_r, vec_s;
    logic [14:0] isr_r, isr_s;
    logic        wr_r, wr_s;
    logic        addr_r, addr_s;
    logic [15:0] din_r, din_s;

    logic [4:0]  isr_top_s;
    logic [4:0]  cur_level_s;
    logic [14:0] eligible_s;
    logic [4:0]  cand_s;

    // Returns {found, index} of the highest set bit of a 15-bit vector.
    function automatic logic [4:0] top_index(input logic [14:0] v);
        logic [4:0] r;
        r = 5'd0;
        for (int i = 0; i < 15; i++) begin
            if (v[i]) begin
                r = {1'b1, 4'(i)};
            end else begin
                r = r;
            end
        end
        return r;
    endfunction

    // Current nesting level and the highest line allowed to interrupt it.
    always_comb begin
        isr_top_s   = top_index(isr_r);
        cur_level_s = isr_top_s[4] ? ({1'b0, isr_top_s[3:0]} + 5'd1) : 5'd0;
        eligible_s  = 15'd0;
        for (int i = 0; i < 15; i++) begin
            if (bus.irq_lines[i] && ((5'(i) + 5'd1) > cur_level_s)) begin
                eligible_s[i] = 1'b1;
            end else begin
                eligible_s[i] = 1'b0;
            end
        end
        cand_s = top_index(eligible_s);
    end

    // Next-state and next-output logic for the handshake FSM.
    always_comb begin
        state_s = state_r;
        req_s   = req_r;
        vec_s   = vec_r;
        wr_s    = 1'b0;
        addr_s  = 1'b0;
        din_s   = 16'd0;
        isr_s   = isr_r;

        // EOI retires the pre-update top level before any ack sets its own bit.
        if (bus.irq_eoi && isr_top_s[4]) begin
            isr_s = isr_r & ~(15'd1 << isr_top_s[3:0]);
        end else begin
            isr_s = isr_r;
        end

        case (state_r)
            ST_IDLE: begin
                if (cand_s[4]) begin
                    vec_s   = cand_s[3:0];
                    req_s   = 1'b1;
                    state_s = ST_REQ;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_REQ: begin
                if (bus.irq_ack) begin
                    isr_s   = isr_s | (15'd1 << vec_r);
                    req_s   = 1'b0;
                    vec_s   = 4'd0;
                    wr_s    = 1'b1;
                    addr_s  = 1'b1;
                    din_s   = {1'b0, 15'd1 << vec_r};
                    state_s = ST_CLEAR;
                end else if (cand_s[4] && (cand_s[3:0] > vec_r)) begin
                    vec_s   = cand_s[3:0];
                end else if (!bus.irq_lines[vec_r]) begin
                    req_s   = 1'b0;
                    vec_s   = 4'd0;
                    state_s = ST_IDLE;
                end else begin
                    state_s = ST_REQ;
                end
            end
            ST_CLEAR: begin
                state_s = ST_IDLE;
            end
            default: begin
                state_s = ST_IDLE;
                req_s   = 1'b0;
                vec_s   = 4'd0;
            end
        endcase
    end

    // State and registered outputs.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_r <= ST_IDLE;
            req_r   <= 1'b0;
            vec_r   <= 4'd0;
            isr_r   <= 15'd0;
            wr_r    <= 1'b0;
            addr_r  <= 1'b0;
            din_r   <= 16'd0;
        end else begin
            state_r <= state_s;
            req_r   <= req_s;
            vec_r   <= vec_s;
            isr_r   <= isr_s;
            wr_r    <= wr_s;
            addr_r  <= addr_s;
            din_r   <= din_s;
        end
    end

    assign bus.irq_req    = req_r;
    assign bus.irq_vector = vec_r;
    assign bus.in_service = isr_r;
    assign bus.ctl_wr     = wr_r;
    assign bus.ctl_addr   = addr_r;
    assign bus.ctl_din    = din_r;

endmodule

// File: doc/irq_dispatcher.md
# irq_dispatcher

Priority dispatcher between `irq_controller` and the CPU. It selects the highest-priority line from the controller's pending-and-enabled vector and presents it to the CPU as a numbered vector with a req/ack handshake. On acknowledge it clears that pending bit by driving the controller's register-write port, and it tracks nested in-service levels until end-of-interrupt.

## Interface
- No parameters. Line count is fixed at 15 and vector width at 4 to match `irq_controller`.
- `clk` input 1: system clock; all state updates on rising edge.
- `reset_n` input 1: asynchronous, active-low reset.
- `irq_lines` input 15: pending & enabled vector from the controller. Bit 14 is highest priority, bit 0 lowest.
- `irq_ack` input 1: CPU accepts the presented vector; sampled only while `irq_req`=1.
- `irq_eoi` input 1: single-cycle end-of-interrupt pulse from the CPU.
- `irq_req` output 1: interrupt request to the CPU.
- `irq_vector` output 4: index (0–14) of the requested line; valid while `irq_req`=1, else 0.
- `in_service` output 15: in-service register.
- `ctl_wr` output 1: write strobe to the controller.
- `ctl_addr` output 1: controller register address; always 1 (PENDING) when `ctl_wr`=1, else 0.
- `ctl_din` output 16: write data; one-hot mask of the acked line in bits 14:0, bit 15 = 0.

## Operation
- **Reset (async, `reset_n`=0):** state=IDLE, and every output is 0: `irq_req`, `irq_vector`, `in_service`, `ctl_wr`, `ctl_addr`, `ctl_din`.
- **Current level:** `cur_level` = 0 if `in_service`==0, else (index of highest set bit of `in_service`) + 1.
- **Eligible line:** line i is eligible when `irq_lines`[i]=1 and i+1 > `cur_level`. The candidate is the highest-index eligible line.
- **IDLE:**
  - If a candidate exists: register `irq_vector`=candidate, set `irq_req`=1, go to REQ.
  - Otherwise stay in IDLE.
- **REQ:** evaluated in this order:
  1. `irq_ack`=1: accept the currently registered `irq_vector`=v. Set `in_service`[v], drop `irq_req`, drive `ctl_wr`=1, `ctl_addr`=1, `ctl_din`=1<<v, go to CLEAR.
  2. Else, if a candidate exists with index > v: replace `irq_vector` with it (pre-emption before ack) and stay in REQ.
  3. Else, if `irq_lines`[v]=0 (line withdrawn by software): drop `irq_req`, set `irq_vector`=0, go to IDLE.
  4. Else hold.
- **CLEAR:** lasts exactly one cycle. The `ctl_*` strobe is high during this cycle. Next cycle: `ctl_wr`=0, `ctl_addr`=0, `ctl_din`=0, state=IDLE. No candidate evaluation takes place in CLEAR.
- **EOI:**
  - `irq_eoi`=1 in any state clears the highest set bit of `in_service`.
  - EOI is ignored when `in_service`==0.
  - EOI and ack in the same cycle: EOI clears the highest bit of the *pre-update* `in_service`, then ack's bit is set. If both refer to the same bit, the bit ends set.
- `irq_ack` outside REQ is ignored. `irq_eoi` wider than one cycle counts once per cycle high.
- Nesting: at most 15 levels, bounded by the `in_service` width. No overflow condition exists.

## Timing
- `irq_lines` eligible bit rises at cycle N (IDLE) → `irq_req`=1 and `irq_vector` valid at N+1.
- Ack sampled at M → at M+1: `irq_req`=0, `in_service` updated, `ctl_wr` pulse. IDLE at M+2; earliest next `irq_req` at M+3.
- The controller's pending clear is visible on `irq_lines` from M+2. The acked line is ineligible anyway via `in_service`.
- EOI at cycle E → `in_service` updated at E+1. A newly eligible lower line can raise `irq_req` at E+2 if in IDLE.
- Pre-emption in REQ: a higher line arriving at cycle P changes `irq_vector` at P+1 with `irq_req` held high; there is no glitch.
- All outputs are registered; there are no combinational paths from inputs to outputs.
- Asserting `reset_n` mid-handshake abandons the sequence immediately. No `ctl_wr` is issued afterwards.

## Test plan
- **Single line:** `irq_lines`=0x0008 → `irq_req`=1, `irq_vector`=3 next cycle. Ack → `ctl_wr` one cycle with `ctl_din`=0x0008, `ctl_addr`=1, `in_service`=0x0008. EOI → `in_service`=0.
- **Priority and pre-emption:**
  - Lines 0x0003 → vector 1.
  - Before ack, raise bit 10 → vector becomes 10 with `irq_req` continuously high.
  - Ack → `ctl_din`=0x0400.
- **Nesting:**
  - In service 0x0020 (line 5): line 2 → no `irq_req`; line 9 → `irq_req`, vector 9. Ack → `in_service`=0x0220.
  - EOI → 0x0020.
  - EOI → 0, then line 2 is dispatched.
- **Withdrawal:** `irq_req` with vector 4; drop `irq_lines`[4] with no ack → `irq_req`=0, `irq_vector`=0, no `ctl_wr`.
- **Simultaneous ack+EOI:** `in_service`=0x0004 with REQ vector 7; ack and EOI in the same cycle → `in_service`=0x0080, and `ctl_din`=0x0080.
- **Async reset:** assert `reset_n`=0 mid-REQ (off clock edge) → all outputs 0 immediately. Release with `irq_lines`=0x4000 → `irq_req`, vector 14, one cycle after the first edge.
